// File: rtl/window5x5_gen_pkg.sv
// Shared constants and window-layout helper for the 5x5 neighbourhood path.
package window5x5_gen_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_N = 5;
  localparam int WIN_W = PIX_W * WIN_N * WIN_N;

  typedef logic [PIX_W-1:0] pix_t;

  // Bit offset of window pixel (r, c); r=0 is the oldest line, c=0 the oldest column.
  function automatic int win_idx(input int r, input int c);
    return (r * WIN_N + c) * PIX_W;
  endfunction

endpackage

// File: rtl/window5x5_gen_line_buffer.sv
// One image line of pixel storage, read and written at the same column each accepted beat.
// The read is combinational so the old pixel at this column joins the window on the
// same edge the new pixel overwrites it.
module window5x5_gen_line_buffer
  import window5x5_gen_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout
);

  pix_t mem [DEPTH];

  // Old contents leave through dout while the new pixel is stored.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/window5x5_gen.sv
// Streaming 5x5 window generator: four chained line buffers feed a 5x5 shift
// window; only windows lying fully inside the image are presented downstream.
module window5x5_gen
  import window5x5_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_pixel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIN_W-1:0]   win_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             at_emit;
  logic             at_last;
  pix_t             lb_in   [4];
  pix_t             lb_out  [4];
  pix_t             col_vec [WIN_N];
  logic [WIN_W-1:0] win_shift;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign at_emit  = (row_q >= RW'(4)) && (col_q >= CW'(4));
  assign at_last  = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Line buffers chained so each one delays the stream by a further line.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_in[gi] = in_pixel;
      end else begin : g_chain
        assign lb_in[gi] = lb_out[gi-1];
      end
      window5x5_gen_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .AW    (CW)
      ) u_lb (
        .clk   (clk),
        .wr_en (accept),
        .addr  (col_q),
        .din   (lb_in[gi]),
        .dout  (lb_out[gi])
      );
    end

    // Newest column: oldest line (LB3) at the top, incoming pixel at the bottom.
    for (gi = 0; gi < WIN_N; gi++) begin : g_colvec
      if (gi == WIN_N - 1) begin : g_new
        assign col_vec[gi] = in_pixel;
      end else begin : g_old
        assign col_vec[gi] = lb_out[3-gi];
      end
    end

    // Window after one shift: columns move left, the new column enters at column 4.
    for (gi = 0; gi < WIN_N; gi++) begin : g_row
      for (gj = 0; gj < WIN_N; gj++) begin : g_col
        if (gj == WIN_N - 1) begin : g_in
          assign win_shift[win_idx(gi, gj) +: PIX_W] = col_vec[gi];
        end else begin : g_sh
          assign win_shift[win_idx(gi, gj) +: PIX_W] = win_q[win_idx(gi, gj + 1) +: PIX_W];
        end
      end
    end
  endgenerate

  // Next-state: counters and window advance only on an accepted pixel.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept) begin
      win_d       = win_shift;
      out_valid_d = at_emit;
      out_last_d  = at_last;
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State registers; reset drops the output and restarts the frame at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign win_out   = win_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_window5x5_gen.sv
// Bench for window5x5_gen on an 8x6 image: expected windows are cut directly out
// of a stored copy of each frame.
module tb_window5x5_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_pixel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [199:0] win_out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;

  window5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .win_out   (win_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [199:0] win;
    logic         last;
    int           cyc;
  } cap_t;

  cap_t         capq [$];
  logic [199:0] exp_win [$];
  logic         exp_last [$];
  logic [7:0]   img [0:1][0:H-1][0:W-1];
  int           pres_cyc [0:H-1][0:W-1];

  int           bp_mode = 0;
  int           bp_i = 0;
  int           stall_cycles = 0;
  int           stall_viol = 0;

  // out_ready driver: 0 always ready, 1 repeating 1-0-0-1, 2 random
  initial begin
    logic [3:0] bp_pat;
    bp_pat = 4'b1001;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        1: begin out_ready = bp_pat[bp_i]; bp_i = (bp_i + 1) % 4; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Collect consumed windows and record stall behaviour
  initial begin
    logic         prev_stall;
    logic [199:0] prev_win;
    prev_stall = 1'b0;
    prev_win = '0;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready)
        capq.push_back('{win: win_out, last: out_last, cyc: cyc});
      if (!rst && out_valid && !out_ready) begin
        stall_cycles++;
        if (in_ready !== 1'b0 || (prev_stall && win_out !== prev_win)) stall_viol++;
        prev_win = win_out;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic fill_pattern(input int f, input bit inv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[f][r][c] = inv ? 8'hFF - 8'((r << 4) | c) : 8'((r << 4) | c);
  endtask

  task automatic fill_random(input int f);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[f][r][c] = 8'($urandom_range(0, 255));
  endtask

  // Every fully-inside window of frame f, in raster order of its bottom-right pixel
  task automatic build_exp(input int f);
    logic [199:0] w;
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++) begin
        for (int wr = 0; wr < 5; wr++)
          for (int wc = 0; wc < 5; wc++)
            w[(5*wr + wc)*8 +: 8] = img[f][r-4+wr][c-4+wc];
        exp_win.push_back(w);
        exp_last.push_back((r == H-1) && (c == W-1));
      end
  endtask

  task automatic send_pix(input logic [7:0] p, input int gap_pct, input int r, input int c);
    int guard;
    while (int'($urandom_range(0, 99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_pixel = p;
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout pixel (%0d,%0d) in_ready=%b required 1", r, c, in_ready);
        break;
      end
    end
    pres_cyc[r][c] = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int f, input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(img[f][r][c], gap_pct, r, c);
  endtask

  task automatic drain();
    bp_mode = 0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    capq.delete();
    exp_win.delete();
    exp_last.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b required 0", out_last); end
    checks++; if (win_out !== 200'd0) begin errors++; $display("FAIL reset_win_out got %h required 0", win_out); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
    $display("tx reset done");
  endtask

  task automatic test_basic();
    clear_all();
    fill_pattern(0, 0);
    build_exp(0);
    send_frame(0, 0);
    drain();
    checks++; if (capq.size() !== 8) begin errors++; $display("FAIL basic_count got %0d required 8", capq.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx basic[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL basic_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
    if (capq.size() == 8) begin
      checks++; if (capq[0].cyc !== pres_cyc[4][4] + 1) begin errors++; $display("FAIL basic_latency got cycle %0d required %0d", capq[0].cyc, pres_cyc[4][4] + 1); end
      checks++; if (capq[0].win[7:0] !== 8'h00) begin errors++; $display("FAIL basic_tl got %h required 00", capq[0].win[7:0]); end
      checks++; if (capq[0].win[39:32] !== 8'h04) begin errors++; $display("FAIL basic_tr got %h required 04", capq[0].win[39:32]); end
      checks++; if (capq[0].win[199:192] !== 8'h44) begin errors++; $display("FAIL basic_br got %h required 44", capq[0].win[199:192]); end
      checks++; if (capq[7].win[199:192] !== 8'h57 || capq[7].last !== 1'b1) begin errors++; $display("FAIL basic_last got %h/%b required 57/1", capq[7].win[199:192], capq[7].last); end
    end
  endtask

  task automatic test_edge_exclusion();
    int bad;
    clear_all();
    fill_pattern(0, 0);
    send_frame(0, 0);
    drain();
    bad = 0;
    foreach (capq[i]) begin
      $display("tx edge[%0d] br=%h", i, capq[i].win[199:192]);
      if (capq[i].win[199:196] < 4'd4 || capq[i].win[195:192] < 4'd4) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL edge_outside_windows got %0d required 0", bad); end
    checks++; if (capq.size() !== 8) begin errors++; $display("FAIL edge_count got %0d required 8", capq.size()); end
    if (capq.size() > 4) begin
      checks++; if (capq[4].win[7:0] !== 8'h10) begin errors++; $display("FAIL edge_row5_tl got %h required 10", capq[4].win[7:0]); end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    fill_pattern(0, 0);
    build_exp(0);
    stall_cycles = 0;
    stall_viol = 0;
    bp_i = 0;
    bp_mode = 1;
    send_frame(0, 0);
    drain();
    checks++; if (stall_cycles < 1) begin errors++; $display("FAIL bp_stall_seen got %0d required >0", stall_cycles); end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d violations required 0", stall_viol); end
    checks++; if (capq.size() !== exp_win.size()) begin errors++; $display("FAIL bp_count got %0d required %0d", capq.size(), exp_win.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx bp[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL bp_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_input_gaps();
    clear_all();
    fill_pattern(0, 0);
    build_exp(0);
    send_frame(0, 50);
    drain();
    checks++; if (capq.size() !== exp_win.size()) begin errors++; $display("FAIL gaps_count got %0d required %0d", capq.size(), exp_win.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx gaps[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL gaps_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int contaminated;
    clear_all();
    fill_pattern(0, 0);
    fill_pattern(1, 1);
    build_exp(0);
    build_exp(1);
    send_frame(0, 0);
    send_frame(1, 0);
    drain();
    checks++; if (capq.size() !== 16) begin errors++; $display("FAIL b2b_count got %0d required 16", capq.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx b2b[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL b2b_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
    if (capq.size() == 16) begin
      checks++; if (capq[8].win[199:192] !== 8'hBB) begin errors++; $display("FAIL b2b_first_br got %h required BB", capq[8].win[199:192]); end
      contaminated = 0;
      for (int i = 8; i < 16; i++)
        for (int b = 0; b < 25; b++)
          for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
              if (capq[i].win[b*8 +: 8] === img[0][r][c]) contaminated++;
      checks++; if (contaminated !== 0) begin errors++; $display("FAIL b2b_stale_data got %0d required 0", contaminated); end
    end
  endtask

  task automatic test_random();
    clear_all();
    fill_random(0);
    fill_random(1);
    build_exp(0);
    build_exp(1);
    bp_mode = 2;
    send_frame(0, 30);
    send_frame(1, 30);
    drain();
    checks++; if (capq.size() !== exp_win.size()) begin errors++; $display("FAIL rand_count got %0d required %0d", capq.size(), exp_win.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx rand[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL rand_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_all();
    fill_pattern(0, 0);
    for (int r = 0; r <= 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 4 || c <= 5) send_pix(img[0][r][c], 0, r, c);
    in_pixel = img[0][4][6];
    in_valid = 1'b1;
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b required 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got %b required 0", out_valid); end
    checks++; if (win_out !== 200'd0) begin errors++; $display("FAIL arst_win_out got %h required 0", win_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clear_all();
    build_exp(0);
    send_frame(0, 0);
    drain();
    checks++; if (capq.size() !== 8) begin errors++; $display("FAIL arst_count got %0d required 8", capq.size()); end
    for (int i = 0; i < capq.size() && i < exp_win.size(); i++) begin
      $display("tx arst[%0d] br=%h last=%b", i, capq[i].win[199:192], capq[i].last);
      checks++;
      if (capq[i].win !== exp_win[i] || capq[i].last !== exp_last[i]) begin
        errors++;
        $display("FAIL arst_win[%0d] got %h/%b required %h/%b", i, capq[i].win, capq[i].last, exp_win[i], exp_last[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_exclusion();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a wait ever goes unbounded
  initial begin
    #2000000;
    $display("FAIL global_timeout reached time %0t required completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
